// File: rtl/evdemux_pkg.sv
// Shared definitions for the 4-way event demultiplexer.
// The load-mask helper is kept here so the top level and any future variants decode the destination the same way.
package evdemux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  // Returns a one-hot mask for a unicast event, or all ones for a broadcast.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_sel_t sel, input logic bcast);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return bcast ? {NUM_CH{1'b1}} : (one << sel);
  endfunction

endpackage

// File: rtl/evdemux_channel.sv
// One output channel: a single registered entry, its free/refill logic, and a saturating delivered-event counter.
// state | meaning
// ------+------------------------------------------------
// EMPTY | no entry held; channel can accept a load
// FULL  | entry held on data; waiting for ready to drain it
module evdemux_channel
  import evdemux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              free,
  output logic              next_valid
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0] state;
  logic       drain;

  assign valid = (state == ST_FULL);
  assign drain = valid & ready;
  // A draining channel counts as free so the next entry can land on the same edge.
  assign free  = ~valid | ready;
  assign next_valid = load | (valid & ~ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
      data  <= '0;
      count <= '0;
    end else begin
      state <= next_valid ? ST_FULL : ST_EMPTY;
      if (load)
        data <= load_data;
      if (drain && (count != {CNT_W{1'b1}}))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/event_demux_4output.sv
// Fans one valid/ready event stream out to four single-entry channels, unicast by in_sel or broadcast to all.
// A broadcast is accepted only when every channel can take it, so it never partially delivers.
module event_demux_4output
  import evdemux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  ch_sel_t                  in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]  out_count,
  output logic                     any_valid
);

  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] next_valid;
  logic [NUM_CH-1:0] load_mask;
  logic              accept;

  assign in_ready  = in_bcast ? (&free) : free[in_sel];
  assign accept    = in_valid & in_ready;
  assign load_mask = ch_onehot(in_sel, in_bcast) & {NUM_CH{accept}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    evdemux_channel #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load       (load_mask[k]),
      .load_data  (in_data),
      .ready      (out_ready[k]),
      .valid      (out_valid[k]),
      .data       (out_data[k*DATA_W +: DATA_W]),
      .count      (out_count[k*CNT_W +: CNT_W]),
      .free       (free[k]),
      .next_valid (next_valid[k])
    );
  end

  // Registered from next-state valids so it lines up with out_valid on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      any_valid <= 1'b0;
    else
      any_valid <= |next_valid;
  end

endmodule

// File: tb/tb_event_demux_4output.sv
// Directed bench for event_demux_4output plus a randomized run against a behavioural reference model.
// A second instance with 2-bit counters exercises counter saturation.
module tb_event_demux_4output;
  import evdemux_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_data;
  logic [63:0] out_count;
  logic        any_valid;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_in_data = '0;
  logic [1:0]  s_in_sel = '0;
  logic        s_in_bcast = 1'b0;
  logic [3:0]  s_out_valid;
  logic [3:0]  s_out_ready = '0;
  logic [31:0] s_out_data;
  logic [7:0]  s_out_count;
  logic        s_any_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  event_demux_4output #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .any_valid(any_valid)
  );

  event_demux_4output #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_sel(s_in_sel), .in_bcast(s_in_bcast),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_count(s_out_count), .any_valid(s_any_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the randomized run
  logic [3:0] mv;
  logic [7:0] md [4];
  int         mcnt [4];

  initial begin
    logic       exp_rdy;
    logic       acc;
    logic       pending;
    logic [3:0] mfree;

    // Reset state
    #12;
    chk("rst_valid", out_valid, 4'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_count", out_count, 64'h0);
    chk("rst_any", any_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // 1: unicast to ch2, one cycle latency
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'h0;
    #1 chk("t1_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 4'b0100);
    chk("t1_data2", out_data[23:16], 8'hA5);
    chk("t1_any", any_valid, 1'b1);

    // 2: backpressure on ch1 then same-cycle refill
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    #1 chk("t2_stall_ready", in_ready, 1'b0);
    step();
    chk("t2_hold_data", out_data[15:8], 8'h11);
    chk("t2_hold_valid", out_valid, 4'b0110);
    out_ready = 4'b0010;
    #1 chk("t2_refill_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ready = 4'h0;
    chk("t2_refill_valid", out_valid, 4'b0110);
    chk("t2_refill_data", out_data[15:8], 8'h22);
    chk("t2_count1", out_count[31:16], 16'd1);

    // 3: broadcast blocked by stalled ch3, then all four load together
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
    step();
    in_bcast = 1'b1; in_data = 8'h3C; in_sel = 2'd0; out_ready = 4'b0110;
    #1 chk("t3_block_ready", in_ready, 1'b0);
    step();
    chk("t3_no_load_valid", out_valid, 4'b1000);
    chk("t3_no_load_data3", out_data[31:24], 8'h77);
    chk("t3_no_load_data0", out_data[7:0], 8'h00);
    out_ready = 4'b1000;
    #1 chk("t3_go_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'h0;
    chk("t3_bc_valid", out_valid, 4'hF);
    chk("t3_bc_data", out_data, 32'h3C3C3C3C);
    chk("t3_counts", out_count, {16'd1, 16'd1, 16'd2, 16'd0});

    // 5: async reset with out_valid=1011
    out_ready = 4'b0100;
    step();
    out_ready = 4'h0;
    chk("t5_pre_valid", out_valid, 4'b1011);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 4'h0);
    chk("t5_rst_count", out_count, 64'h0);
    chk("t5_rst_any", any_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("t5_post_valid", out_valid, 4'h0);
    chk("t5_post_any", any_valid, 1'b0);

    // 4: 2-bit counter saturates after 5 handshakes on ch0
    s_in_valid = 1'b1; s_in_sel = 2'd0; s_out_ready = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      s_in_data = 8'(i + 1);
      step();
    end
    s_in_valid = 1'b0;
    chk("t4_cnt4", s_out_count[1:0], 2'd3);
    step();
    step();
    chk("t4_sat", s_out_count[1:0], 2'd3);
    chk("t4_idle", s_out_valid, 4'h0);
    s_out_ready = 4'h0;

    // 6: randomized traffic against the reference model
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mv = '0;
    for (int k = 0; k < 4; k++) begin
      md[k] = '0;
      mcnt[k] = 0;
    end
    pending = 1'b0;
    step();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd_valid", out_valid, mv);
      chk("rnd_any", any_valid, |mv);
      for (int k = 0; k < 4; k++) begin
        if (mv[k])
          chk("rnd_data", out_data[k*8 +: 8], md[k]);
        chk("rnd_count", out_count[k*16 +: 16], mcnt[k][15:0]);
      end
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_bcast = ($urandom_range(0, 5) == 0);
        in_data  = 8'($urandom_range(0, 255));
      end
      out_ready = 4'($urandom_range(0, 15));
      mfree = ~mv | out_ready;
      exp_rdy = in_bcast ? (&mfree) : mfree[in_sel];
      #1 chk("rnd_ready", in_ready, exp_rdy);
      acc = in_valid & exp_rdy;
      pending = in_valid & ~acc;
      for (int k = 0; k < 4; k++) begin
        if (mv[k] && out_ready[k])
          mcnt[k] = mcnt[k] + 1;
        if (acc && (in_bcast || (in_sel == 2'(k)))) begin
          mv[k] = 1'b1;
          md[k] = in_data;
        end else if (out_ready[k]) begin
          mv[k] = 1'b0;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
